// File: rtl/afifo_frame_reader_if.sv
// Signal bundle between the TX async FIFO read port, the frame reader and the MAC byte stream.
// master = the frame reader, slave = the FIFO/MAC side that drives it.
interface afifo_frame_reader_if #(
  parameter int DATA_WIDTH = 36
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_data_valid;
  logic                  fifo_rd_rst_busy;
  logic [4:0]            fifo_rd_data_count;
  logic                  fifo_rd_en;

  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_sop;
  logic                  tx_eop;
  logic                  tx_underrun;

  logic                  frame_done;
  logic [15:0]           frame_len;
  logic                  sop_err;

  modport master (
    input  fifo_dout, fifo_data_valid, fifo_rd_rst_busy, fifo_rd_data_count, tx_ready,
    output fifo_rd_en, tx_data, tx_valid, tx_sop, tx_eop, tx_underrun,
           frame_done, frame_len, sop_err
  );

  modport slave (
    output fifo_dout, fifo_data_valid, fifo_rd_rst_busy, fifo_rd_data_count, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid, tx_sop, tx_eop, tx_underrun,
           frame_done, frame_len, sop_err
  );
endinterface

// File: rtl/afifo_frame_reader.sv
// Drains framed 36-bit words from an FWFT FIFO and serialises them into a byte stream for the MAC,
// aborting a frame on mid-frame underrun and discarding the rest of it.
module afifo_frame_reader #(
  parameter int DATA_WIDTH   = 36,
  parameter int START_THRESH = 4
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  afifo_frame_reader_if.master bus
);

  localparam logic [4:0] THRESH = 5'(START_THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q;
  logic [35:0] wbuf_q;
  logic [1:0]  byte_idx_q;
  logic [15:0] len_q;
  logic        first_q;
  logic [15:0] frame_len_q;
  logic        tx_underrun_q;
  logic        frame_done_q;
  logic        sop_err_q;

  logic        head_ok;
  logic        head_sop;
  logic        head_eop;
  logic        start_ok;
  logic        sending;
  logic        last_byte;
  logic        accept;
  logic        rd_en_d;
  logic [15:0] len_d;
  logic [35:0] head_word;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign head_word = bus.fifo_dout[35:0];
  // A head word is usable only when valid, the FIFO read side is out of reset, and we are not in reset.
  assign head_ok   = bus.fifo_data_valid & ~bus.fifo_rd_rst_busy & ~rst;
  assign head_sop  = head_word[32];
  assign head_eop  = head_word[33];
  assign start_ok  = head_sop & (head_eop | (bus.fifo_rd_data_count >= THRESH));

  assign sending   = (state_q == SEND);
  assign last_byte = wbuf_q[33] ? (byte_idx_q == wbuf_q[35:34]) : (byte_idx_q == 2'd3);
  assign accept    = sending & bus.tx_ready;
  assign len_d     = sat_inc16(len_q);

  always_comb begin
    rd_en_d = 1'b0;
    unique case (state_q)
      IDLE:    rd_en_d = head_ok & (~head_sop | start_ok);
      SEND:    rd_en_d = accept & last_byte & ~wbuf_q[33] & head_ok;
      DRAIN:   rd_en_d = head_ok & ~head_sop;
      default: rd_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wbuf_q        <= '0;
      byte_idx_q    <= '0;
      len_q         <= '0;
      first_q       <= 1'b0;
      frame_len_q   <= '0;
      tx_underrun_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sop_err_q     <= 1'b0;
    end else begin
      tx_underrun_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sop_err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (head_ok) begin
            if (!head_sop) begin
              sop_err_q <= 1'b1;
            end else if (start_ok) begin
              wbuf_q     <= head_word;
              byte_idx_q <= '0;
              len_q      <= '0;
              first_q    <= 1'b1;
              state_q    <= SEND;
            end
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            len_q   <= len_d;
            first_q <= 1'b0;
            if (last_byte) begin
              if (wbuf_q[33]) begin
                frame_len_q  <= len_d;
                frame_done_q <= 1'b1;
                state_q      <= IDLE;
              end else if (head_ok) begin
                // Refill in the same cycle so the byte stream has no bubble between words.
                wbuf_q     <= head_word;
                byte_idx_q <= '0;
              end else begin
                tx_underrun_q <= 1'b1;
                state_q       <= DRAIN;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        DRAIN: begin
          // A SOP head is left in place: it is the start of the next frame.
          if (head_ok && (head_sop || head_eop)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en  = rd_en_d;
  assign bus.tx_valid    = sending;
  assign bus.tx_data     = wbuf_q[{byte_idx_q, 3'b000} +: 8];
  assign bus.tx_sop      = sending & first_q;
  assign bus.tx_eop      = sending & wbuf_q[33] & last_byte;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.sop_err     = sop_err_q;

endmodule

// File: tb/tb_afifo_frame_reader.sv
// Bench for afifo_frame_reader: a queue models the FIFO, frames are built from random bytes and
// the expected byte stream is derived from the frame contents.
module tb_afifo_frame_reader;

  logic rd_clk = 1'b0;
  logic rst;
  always #5 rd_clk = ~rd_clk;

  afifo_frame_reader_if #(.DATA_WIDTH(36)) bus ();

  afifo_frame_reader #(.DATA_WIDTH(36), .START_THRESH(4)) dut (
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [35:0] fq[$];
  logic [35:0] stage[$];
  logic [7:0]  fb[$];
  logic [7:0]  got_b[$];
  bit          got_sop[$];
  bit          got_eop[$];
  logic [7:0]  exp_b[$];
  bit          exp_sop[$];
  bit          exp_eop[$];

  int n_done, n_underrun, n_sop_err, n_rd_en;
  int first_acc, last_acc;
  int ready_pct = 100;
  bit busy = 1'b0;

  bit         prev_stall;
  logic [7:0] prev_d;
  logic       prev_s, prev_e;
  logic       s_rd_en, s_tx_valid, s_sop, s_sop_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.fifo_dout          = (fq.size() != 0) ? fq[0] : 36'd0;
    bus.fifo_data_valid    = (fq.size() != 0);
    bus.fifo_rd_data_count = (fq.size() > 31) ? 5'd31 : 5'(fq.size());
    bus.fifo_rd_rst_busy   = busy;
  endtask

  task automatic clr();
    n_done = 0; n_underrun = 0; n_sop_err = 0; n_rd_en = 0;
    first_acc = -1; last_acc = -1;
    got_b.delete(); got_sop.delete(); got_eop.delete();
    exp_b.delete(); exp_sop.delete(); exp_eop.delete();
  endtask

  // One clock: observe at the falling edge, apply FIFO pops and new inputs just after the rising edge.
  task automatic step();
    @(negedge rd_clk);
    s_rd_en    = bus.fifo_rd_en;
    s_tx_valid = bus.tx_valid;
    s_sop      = bus.tx_sop;
    s_sop_err  = bus.sop_err;
    if (bus.fifo_rd_en) begin
      n_rd_en++;
      chk("rd_en_gate", {bus.fifo_data_valid, bus.fifo_rd_rst_busy}, 2'b10);
    end
    if (prev_stall && !rst)
      chk("stall_hold", {bus.tx_valid, bus.tx_sop, bus.tx_eop, bus.tx_data},
          {1'b1, prev_s, prev_e, prev_d});
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      got_b.push_back(bus.tx_data);
      got_sop.push_back(bus.tx_sop);
      got_eop.push_back(bus.tx_eop);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    n_done     += int'(bus.frame_done);
    n_underrun += int'(bus.tx_underrun);
    n_sop_err  += int'(bus.sop_err);
    prev_stall = bus.tx_valid & ~bus.tx_ready & ~rst;
    prev_d = bus.tx_data; prev_s = bus.tx_sop; prev_e = bus.tx_eop;
    @(posedge rd_clk);
    #1;
    cyc++;
    if (s_rd_en && fq.size() > 0) void'(fq.pop_front());
    bus.tx_ready = ($urandom_range(99) < ready_pct);
    drive();
  endtask

  task automatic run_quiet(input int budget, input string tag);
    int q = 0;
    int n = 0;
    while (n < budget && !(fq.size() == 0 && q >= 4)) begin
      step();
      n++;
      q = (s_tx_valid || s_rd_en) ? 0 : q + 1;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  // Builds an nbytes frame from random bytes; padding bytes and non-EOP length fields are junk.
  task automatic add_frame(input int n, input bit expect_sent, input bit to_stage);
    int nw = (n + 3) / 4;
    logic [35:0] w;
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    for (int k = 0; k < nw; k++) begin
      w = 36'($urandom);
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) w[8*j +: 8] = fb[4*k+j];
      w[32] = (k == 0);
      w[33] = (k == nw - 1);
      w[35:34] = (k == nw - 1) ? 2'((n - 1) % 4) : 2'($urandom);
      if (to_stage) stage.push_back(w); else fq.push_back(w);
    end
    if (expect_sent)
      for (int i = 0; i < n; i++) begin
        exp_b.push_back(fb[i]);
        exp_sop.push_back(i == 0);
        exp_eop.push_back(i == n - 1);
      end
    drive();
  endtask

  task automatic compare_stream(input string tag);
    int mism = 0;
    chk({tag, "_nbytes"}, 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      if (got_b[i] !== exp_b[i] || got_sop[i] != exp_sop[i] || got_eop[i] != exp_eop[i]) mism++;
    chk({tag, "_bytes"}, 64'(mism), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int remaining, eops, lastlen, n;
    rst = 1'b1;
    bus.tx_ready = 1'b1;
    fq.delete();
    drive();
    clr();
    prev_stall = 1'b0;
    repeat (3) step();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_flags", {bus.tx_sop, bus.tx_eop, bus.tx_underrun, bus.frame_done, bus.sop_err}, 0);
    chk("rst_frame_len", bus.frame_len, 0);
    rst = 1'b0;

    // 64-byte frame, always ready: contiguous bytes
    clr();
    add_frame(64, 1, 0);
    run_quiet(500, "f64");
    chk("f64_contig", 64'(last_acc - first_acc), 64'd63);
    chk("f64_done", 64'(n_done), 64'd1);
    chk("f64_len", bus.frame_len, 64);
    compare_stream("f64");

    // single-word frame starts with one cycle of latency
    clr();
    add_frame(2, 1, 0);
    step();
    chk("lat_pop", s_rd_en, 1);
    step();
    chk("lat_first_byte", {s_tx_valid, s_sop}, 2'b11);
    run_quiet(100, "f2");
    chk("f2_len", bus.frame_len, 2);
    compare_stream("f2");

    // multi-word head waits for the start threshold
    clr();
    add_frame(5, 1, 0);
    repeat (20) step();
    chk("thr_wait_bytes", 64'(got_b.size()), 64'd0);
    chk("thr_wait_fifo", 64'(fq.size()), 64'd2);
    add_frame(2, 1, 0);
    add_frame(3, 1, 0);
    run_quiet(200, "thr");
    chk("thr_done", 64'(n_done), 64'd3);
    chk("thr_len", bus.frame_len, 3);
    compare_stream("thr");

    // 60-byte frame with random back-pressure
    clr();
    ready_pct = 50;
    add_frame(60, 1, 0);
    run_quiet(2000, "stall");
    chk("stall_len", bus.frame_len, 60);
    compare_stream("stall");

    // underrun after four words of a ten-word frame
    clr();
    ready_pct = 100;
    stage.delete();
    add_frame(40, 0, 1);
    for (int i = 0; i < 16; i++) begin
      exp_b.push_back(fb[i]);
      exp_sop.push_back(i == 0);
      exp_eop.push_back(1'b0);
    end
    repeat (4) fq.push_back(stage.pop_front());
    drive();
    run_quiet(200, "urun");
    chk("urun_pulse", 64'(n_underrun), 64'd1);
    chk("urun_no_done", 64'(n_done), 64'd0);
    chk("urun_len_kept", bus.frame_len, 60);
    compare_stream("urun");
    clr();
    while (stage.size() > 0) fq.push_back(stage.pop_front());
    add_frame(20, 1, 0);
    run_quiet(300, "drain");
    chk("drain_done", 64'(n_done), 64'd1);
    chk("drain_len", bus.frame_len, 20);
    compare_stream("drain");

    // head word without SOP in IDLE
    clr();
    fq.push_back({2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF});
    drive();
    step();
    chk("soperr_pop", s_rd_en, 1);
    step();
    chk("soperr_pulse", s_sop_err, 1);
    step();
    chk("soperr_once", s_sop_err, 0);
    chk("soperr_no_tx", 64'(got_b.size()), 64'd0);

    // random frames with random back-pressure
    clr();
    ready_pct = 70;
    lastlen = 0;
    for (int i = 0; i < 6; i++) begin
      n = (i % 2 == 1) ? int'($urandom_range(100, 13)) : int'($urandom_range(4, 1));
      add_frame(n, 1, 0);
      lastlen = n;
    end
    run_quiet(5000, "rnd");
    chk("rnd_done", 64'(n_done), 64'd6);
    chk("rnd_len", bus.frame_len, 64'(lastlen));
    compare_stream("rnd");

    // FIFO read side busy: no pops
    clr();
    ready_pct = 100;
    busy = 1'b1;
    add_frame(3, 1, 0);
    repeat (10) step();
    chk("busy_no_pop", 64'(n_rd_en), 64'd0);
    chk("busy_fifo", 64'(fq.size()), 64'd1);
    busy = 1'b0;
    drive();
    run_quiet(100, "busy");
    chk("busy_len", bus.frame_len, 3);
    compare_stream("busy");

    // reset in the middle of a frame
    clr();
    add_frame(40, 0, 0);
    repeat (6) step();
    rst = 1'b1;
    ready_pct = 0;
    bus.tx_ready = 1'b0;
    step();
    chk("mrst_tx_valid", bus.tx_valid, 0);
    chk("mrst_rd_en", bus.fifo_rd_en, 0);
    chk("mrst_outs", {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_underrun, bus.frame_done,
                      bus.sop_err}, 0);
    chk("mrst_len", bus.frame_len, 0);
    remaining = fq.size();
    rst = 1'b0;
    ready_pct = 100;
    drive();
    run_quiet(300, "mrst");
    eops = 0;
    foreach (got_eop[i]) eops += int'(got_eop[i]);
    chk("mrst_no_eop", 64'(eops), 64'd0);
    chk("mrst_no_urun", 64'(n_underrun), 64'd0);
    chk("mrst_soperr", 64'(n_sop_err), 64'(remaining));
    chk("mrst_no_done", 64'(n_done), 64'd0);

    clr();
    add_frame(4, 1, 0);
    run_quiet(100, "post");
    chk("post_len", bus.frame_len, 4);
    compare_stream("post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
